// File: rtl/dmi_pkg.sv
// dmi_pkg: shared definitions for the DMI initiator.
//   - DMI address/data widths
//   - request op and response op encodings
//   - initiator FSM state enum
package dmi_pkg;

  localparam int unsigned DMI_ADDR_W = 7;
  localparam int unsigned DMI_DATA_W = 32;

  // Request op encodings
  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [1:0] DMI_OP_RSVD  = 2'd3;

  // Response op encodings
  localparam logic [1:0] DMI_RSP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RSP_FAILED  = 2'd2;
  localparam logic [1:0] DMI_RSP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } dmi_state_e;

endpackage

// File: rtl/dmi_initiator.sv
// dmi_initiator: bridges a host valid/ready request/response channel onto a
// strobe-based DM register port, tracking a sticky error/busy status.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          host request handshake
//   req_op/req_addr/req_data     host request (op 0 nop, 1 read, 2 write, 3 reserved)
//   dmi_reset_req                clears the sticky status
//   rsp_valid/rsp_ready          host response handshake
//   rsp_data/rsp_op              response data and status (0 ok, 2 failed, 3 busy)
//   dmi_ready                    one-cycle DM request strobe
//   dmi_address_out/_writedata   DM address and write payload
//   dmi_read/dmi_write           DM strobes: dmi_read marks a host write,
//                                dmi_write marks a host read (DM port convention)
//   dmi_readdata/dmi_rsp_valid   DM completion data and pulse
//
// Build option: define DMI_TIMEOUT_EN to fail a WAIT that lasts TIMEOUT_CYCLES.
module dmi_initiator
  import dmi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DMI_ADDR_W-1:0] req_addr,
  input  logic [DMI_DATA_W-1:0] req_data,
  input  logic                  dmi_reset_req,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DMI_DATA_W-1:0] rsp_data,
  output logic [1:0]            rsp_op,
  output logic                  dmi_ready,
  output logic [DMI_ADDR_W-1:0] dmi_address_out,
  output logic                  dmi_read,
  output logic                  dmi_write,
  output logic [DMI_DATA_W-1:0] dmi_writedata,
  input  logic [DMI_DATA_W-1:0] dmi_readdata,
  input  logic                  dmi_rsp_valid
);

  dmi_state_e            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DMI_ADDR_W-1:0] addr_q, addr_d;
  logic [DMI_DATA_W-1:0] data_q, data_d;
  logic [DMI_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_op_q, rsp_op_d;
  logic [1:0]            sticky_q, sticky_d;
  logic                  set_failed;

`ifdef DMI_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_op_d   = rsp_op_q;
    sticky_d   = sticky_q;
    set_failed = 1'b0;
`ifdef DMI_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          op_d       = req_op;
          addr_d     = req_addr;
          data_d     = req_data;
          rsp_data_d = '0;
          if ((req_op == DMI_OP_READ || req_op == DMI_OP_WRITE) &&
              sticky_q == DMI_RSP_SUCCESS) begin
            state_d = StIssue;
          end else begin
            // Short-circuit response: nop, reserved op, or sticky status replay
            state_d = StResp;
            if (req_op == DMI_OP_NOP) begin
              rsp_op_d = DMI_RSP_SUCCESS;
            end else if (req_op == DMI_OP_RSVD) begin
              rsp_op_d   = DMI_RSP_FAILED;
              set_failed = 1'b1;
            end else begin
              rsp_op_d = sticky_q;
            end
          end
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef DMI_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      StWait: begin
        if (dmi_rsp_valid) begin
          state_d    = StResp;
          rsp_data_d = (op_q == DMI_OP_READ) ? dmi_readdata : '0;
          rsp_op_d   = DMI_RSP_SUCCESS;
        end
`ifdef DMI_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          state_d    = StResp;
          rsp_data_d = '0;
          rsp_op_d   = DMI_RSP_FAILED;
          set_failed = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear beats any set; failed overrides busy; busy only from clean status
    if (dmi_reset_req) begin
      sticky_d = DMI_RSP_SUCCESS;
    end else if (set_failed) begin
      sticky_d = DMI_RSP_FAILED;
    end else if (req_valid && state_q != StIdle && sticky_q == DMI_RSP_SUCCESS) begin
      sticky_d = DMI_RSP_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= DMI_OP_NOP;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_op_q   <= DMI_RSP_SUCCESS;
      sticky_q   <= DMI_RSP_SUCCESS;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_op_q   <= rsp_op_d;
      sticky_q   <= sticky_d;
    end
  end

`ifdef DMI_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // rst gating keeps the host from handing over a request during reset
  assign req_ready       = (state_q == StIdle) && !dmi_reset_req && !rst;
  assign rsp_valid       = (state_q == StResp);
  assign rsp_data        = rsp_data_q;
  assign rsp_op          = rsp_op_q;
  assign dmi_ready       = (state_q == StIssue);
  assign dmi_read        = (state_q == StIssue) && (op_q == DMI_OP_WRITE);
  assign dmi_write       = (state_q == StIssue) && (op_q == DMI_OP_READ);
  assign dmi_address_out = addr_q;
  assign dmi_writedata   = data_q;

endmodule

// File: tb/tb_dmi_initiator.sv
module tb_dmi_initiator;
  import dmi_pkg::*;

  localparam int TO_CYCLES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic        dmi_reset_req;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_op;
  logic        dmi_ready;
  logic [6:0]  dmi_address_out;
  logic        dmi_read;
  logic        dmi_write;
  logic [31:0] dmi_writedata;
  logic [31:0] dmi_readdata;
  logic        dmi_rsp_valid;

  int n_checks = 0;
  int n_err    = 0;
  int model_sticky = 0;  // 0 clean, 2 failed, 3 busy

  dmi_initiator #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .dmi_reset_req   (dmi_reset_req),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_op          (rsp_op),
    .dmi_ready       (dmi_ready),
    .dmi_address_out (dmi_address_out),
    .dmi_read        (dmi_read),
    .dmi_write       (dmi_write),
    .dmi_writedata   (dmi_writedata),
    .dmi_readdata    (dmi_readdata),
    .dmi_rsp_valid   (dmi_rsp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_sticky();
    @(negedge clk);
    dmi_reset_req = 1'b1;
    #1 chk("req_ready_during_reset_req", req_ready, 0);
    @(negedge clk);
    dmi_reset_req = 1'b0;
    model_sticky = 0;
  endtask

  // Entered at a negedge where the response is expected to be present.
  task automatic finish_rsp(input logic [1:0] exp_op, input logic [31:0] exp_data, input int bp);
    #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_op", rsp_op, exp_op);
    chk("rsp_data", rsp_data, exp_data);
    for (int i = 0; i < bp; i++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, exp_data);
      chk("bp_rsp_op", rsp_op, exp_op);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_done", rsp_valid, 0);
    chk("req_ready_after", req_ready, 1);
  endtask

  // One host transaction plus DM behaviour; expectations come from model_sticky.
  task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] rdata, input int bp, input bit poke);
    bit          issue;
    logic [1:0]  exp_op;
    logic [31:0] exp_data;
    issue = (op == 2'd1 || op == 2'd2) && model_sticky == 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = wdata;
    #1 chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    if (issue) begin
      chk("dmi_ready", dmi_ready, 1);
      chk("dmi_write_on_read", dmi_write, op == 2'd1);
      chk("dmi_read_on_write", dmi_read, op == 2'd2);
      chk("dmi_address", dmi_address_out, addr);
      if (op == 2'd2) chk("dmi_writedata", dmi_writedata, wdata);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        req_valid = 1'b0;
        if (poke && i == 0) begin
          req_valid = 1'b1;
          req_op    = DMI_OP_READ;
          #1 chk("req_ready_busy", req_ready, 0);
          if (model_sticky == 0) model_sticky = 3;
        end
        #1 chk("no_strobe_in_wait", {dmi_ready, dmi_read, dmi_write}, 0);
      end
      @(negedge clk);
      req_valid     = 1'b0;
      dmi_rsp_valid = 1'b1;
      dmi_readdata  = rdata;
      @(negedge clk);
      dmi_rsp_valid = 1'b0;
      dmi_readdata  = $urandom;
      exp_op   = 2'd0;
      exp_data = (op == 2'd1) ? rdata : 32'd0;
    end else begin
      chk("no_strobe_short", {dmi_ready, dmi_read, dmi_write}, 0);
      exp_data = 32'd0;
      if (op == 2'd0) exp_op = 2'd0;
      else if (op == 2'd3) begin
        exp_op = 2'd2;
        model_sticky = 2;
      end else exp_op = 2'(model_sticky);
    end
    finish_rsp(exp_op, exp_data, bp);
  endtask

  initial begin
    int k;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_data = '0;
    dmi_reset_req = 1'b0; rsp_ready = 1'b0; dmi_readdata = '0; dmi_rsp_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_op", rsp_op, 0);
    chk("rst_strobes", {dmi_ready, dmi_read, dmi_write}, 0);
    chk("rst_addr", dmi_address_out, 0);
    chk("rst_wdata", dmi_writedata, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("req_ready_after_rst", req_ready, 1);

    // Directed read / write / backpressure
    do_txn(DMI_OP_READ, 7'h11, 32'h0, 2, 32'h0000_0C82, 0, 1'b0);
    do_txn(DMI_OP_WRITE, 7'h04, 32'hDEAD_BEEF, 1, 32'h1234_5678, 0, 1'b0);
    do_txn(DMI_OP_READ, 7'h22, 32'h0, 1, 32'hCAFE_F00D, 5, 1'b0);

    // Busy overrun, sticky replay, then clear
    do_txn(DMI_OP_READ, 7'h10, 32'h0, 3, 32'h0000_00AA, 0, 1'b1);
    do_txn(DMI_OP_READ, 7'h10, 32'h0, 1, 32'h0000_00BB, 0, 1'b0);
    clear_sticky();
    do_txn(DMI_OP_READ, 7'h10, 32'h0, 1, 32'h0000_00CC, 0, 1'b0);

    // Reserved op fails and sticks; nop still succeeds
    do_txn(DMI_OP_RSVD, 7'h01, 32'h0, 1, 32'h0, 0, 1'b0);
    do_txn(DMI_OP_WRITE, 7'h05, 32'h5555_AAAA, 1, 32'h0, 0, 1'b0);
    do_txn(DMI_OP_NOP, 7'h00, 32'h0, 1, 32'h0, 1, 1'b0);
    clear_sticky();

    // DM never answers
    @(negedge clk);
    req_valid = 1'b1; req_op = DMI_OP_READ; req_addr = 7'h33;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("to_strobe", dmi_ready, 1);
    @(negedge clk);
    k = 0;
`ifdef DMI_TIMEOUT_EN
    while (!rsp_valid && k < 4 * TO_CYCLES) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", k, TO_CYCLES);
    model_sticky = 2;
    finish_rsp(2'd2, 32'd0, 0);
    do_txn(DMI_OP_READ, 7'h33, 32'h0, 1, 32'h0, 0, 1'b0);
    clear_sticky();
`else
    repeat (1000) @(negedge clk);
    #1;
    chk("still_wait_rsp_valid", rsp_valid, 0);
    chk("still_wait_req_ready", req_ready, 0);
    @(negedge clk);
    dmi_rsp_valid = 1'b1; dmi_readdata = 32'h0BAD_F00D;
    @(negedge clk);
    dmi_rsp_valid = 1'b0;
    finish_rsp(2'd0, 32'h0BAD_F00D, 0);
`endif

    // Reset mid-WAIT, late DM completion ignored
    @(negedge clk);
    req_valid = 1'b1; req_op = DMI_OP_WRITE; req_addr = 7'h44; req_data = 32'h1111_2222;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_strobes", {dmi_ready, dmi_read, dmi_write}, 0);
    chk("midrst_addr", dmi_address_out, 0);
    chk("midrst_wdata", dmi_writedata, 0);
    chk("midrst_rsp", {rsp_data, rsp_op}, 0);
    rst = 1'b0;
    dmi_rsp_valid = 1'b1;
    model_sticky = 0;
    @(negedge clk);
    dmi_rsp_valid = 1'b0;
    #1;
    chk("late_rsp_ignored", rsp_valid, 0);
    chk("late_req_ready", req_ready, 1);

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      int          r;
      logic [1:0]  op;
      r = $urandom_range(0, 9);
      op = (r == 0) ? DMI_OP_NOP : (r == 1) ? DMI_OP_RSVD : (r < 6) ? DMI_OP_READ : DMI_OP_WRITE;
      do_txn(op, 7'($urandom), $urandom, $urandom_range(1, 4), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 5) == 0);
      if (model_sticky != 0 && $urandom_range(0, 1) == 1) clear_sticky();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
